// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus port endpoint: ID field width, broadcast ID,
// saturating counter type and the destination-ID extractor.
package bus_pkg;

  localparam int ID_W    = 8;
  localparam int PKT_MAX = 64;
  localparam logic [ID_W-1:0] BROADCAST = 8'hFF;

  typedef logic [15:0] sat_cnt_t;

  // Destination ID is the top ID_W bits of a pkt_w-bit packet (zero-extended to PKT_MAX).
  function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX-1:0] pkt,
                                                input int unsigned pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

  function automatic sat_cnt_t sat_inc(input sat_cnt_t c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/ep_fifo.sv
// Show-ahead FIFO; write visible on empty/rdata one cycle later, head is 0 when empty.
// Write while full lands only if a read frees the slot on the same edge; read on empty is ignored.
module ep_fifo #(
  parameter int width = 16,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wdata,
  input  logic             rd,
  output logic [width-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic             do_wr, do_rd;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    // Pointers carry one extra MSB so equal indices with differing MSBs means full.
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd    = rd && !empty;
    do_wr    = wr && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: empty masks the head until an entry is written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bus_port_endpoint.sv
// Device-side bus port: TX FIFO toward the bus, ID-filtered RX FIFO toward the host.
// All outputs come from registered state; RX overflow and misroutes are counted, never stalled.
module bus_port_endpoint
  import bus_pkg::*;
#(
  parameter int          pckg_sz    = 16,
  parameter int          fifo_depth = 16,
  parameter logic [7:0]  my_id      = 8'd0,
  parameter logic [7:0]  broadcast  = BROADCAST
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_valid,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        misroute_cnt,
  output logic               err_underrun
);

  logic            tx_empty, rx_empty, rx_full;
  logic            id_hit, rx_wr;
  logic [ID_W-1:0] dest;
  sat_cnt_t        drop_cnt_q, drop_cnt_d;
  sat_cnt_t        misroute_cnt_q, misroute_cnt_d;
  logic            err_underrun_q, err_underrun_d;

  ep_fifo #(.width(pckg_sz), .depth(fifo_depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (pop),
    .rdata (D_pop),
    .empty (tx_empty),
    .full  (tx_full)
  );

  ep_fifo #(.width(pckg_sz), .depth(fifo_depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_wr),
    .wdata (D_push),
    .rd    (rx_rd),
    .rdata (rx_data),
    .empty (rx_empty),
    .full  (rx_full)
  );

  always_comb begin
    dest   = get_dest(PKT_MAX'(D_push), pckg_sz);
    id_hit = (dest == my_id) || (dest == broadcast);
    // Full is judged before the edge, so a same-cycle rx_rd never makes room.
    rx_wr  = push && id_hit && !rx_full;

    drop_cnt_d     = drop_cnt_q;
    misroute_cnt_d = misroute_cnt_q;
    err_underrun_d = err_underrun_q || (pop && tx_empty);
    if (push && id_hit && rx_full) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
    if (push && !id_hit) begin
      misroute_cnt_d = sat_inc(misroute_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q     <= '0;
      misroute_cnt_q <= '0;
      err_underrun_q <= 1'b0;
    end else begin
      drop_cnt_q     <= drop_cnt_d;
      misroute_cnt_q <= misroute_cnt_d;
      err_underrun_q <= err_underrun_d;
    end
  end

  assign pndng        = !tx_empty;
  assign rx_valid     = !rx_empty;
  assign drop_cnt     = drop_cnt_q;
  assign misroute_cnt = misroute_cnt_q;
  assign err_underrun = err_underrun_q;

endmodule

// File: tb/tb_bus_port_endpoint.sv
// Directed and randomized bench for bus_port_endpoint (my_id=2, depth 16) against a queue-based model.
module tb_bus_port_endpoint;

  localparam int DEPTH = 16;
  localparam logic [7:0] MY_ID = 8'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop = 1'b0;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic        tx_wr = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_full;
  logic        rx_rd = 1'b0;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic [15:0] drop_cnt;
  logic [15:0] misroute_cnt;
  logic        err_underrun;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] tx_m [$];
  logic [15:0] rx_m [$];
  int          drop_m = 0;
  int          mis_m  = 0;
  bit          und_m  = 0;

  always #5 clk = ~clk;

  bus_port_endpoint #(
    .pckg_sz(16), .fifo_depth(DEPTH), .my_id(MY_ID), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_full(tx_full), .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
    .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt), .err_underrun(err_underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pndng",        pndng,        32'(tx_m.size() != 0));
    chk("d_pop",        D_pop,        (tx_m.size() != 0) ? 32'(tx_m[0]) : 32'h0);
    chk("tx_full",      tx_full,      32'(tx_m.size() == DEPTH));
    chk("rx_valid",     rx_valid,     32'(rx_m.size() != 0));
    chk("rx_data",      rx_data,      (rx_m.size() != 0) ? 32'(rx_m[0]) : 32'h0);
    chk("drop_cnt",     drop_cnt,     32'(drop_m));
    chk("misroute_cnt", misroute_cnt, 32'(mis_m));
    chk("err_underrun", err_underrun, 32'(und_m));
  endtask

  task automatic model_clear();
    tx_m.delete();
    rx_m.delete();
    drop_m = 0;
    mis_m  = 0;
    und_m  = 0;
  endtask

  // What one clock edge does, stated from the port-level rules.
  task automatic model_step(input bit wr, input logic [15:0] wd, input bit p,
                            input bit ps, input logic [15:0] pd, input bit rd);
    bit         tx_was_full;
    bit         rx_was_full;
    bit         popped;
    logic [7:0] dst;
    tx_was_full = (tx_m.size() == DEPTH);
    rx_was_full = (rx_m.size() == DEPTH);
    popped      = 0;
    dst         = pd[15:8];
    if (p) begin
      if (tx_m.size() > 0) begin
        void'(tx_m.pop_front());
        popped = 1;
      end else begin
        und_m = 1;
      end
    end
    if (wr && (!tx_was_full || popped)) tx_m.push_back(wd);
    if (rd && rx_m.size() > 0) void'(rx_m.pop_front());
    if (ps) begin
      if (dst == MY_ID || dst == 8'hFF) begin
        if (rx_was_full) drop_m = (drop_m < 65535) ? drop_m + 1 : drop_m;
        else             rx_m.push_back(pd);
      end else begin
        mis_m = (mis_m < 65535) ? mis_m + 1 : mis_m;
      end
    end
  endtask

  task automatic cyc(input bit wr, input logic [15:0] wd, input bit p,
                     input bit ps, input logic [15:0] pd, input bit rd);
    tx_wr = wr; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = rd;
    @(posedge clk);
    #1;
    model_step(wr, wd, p, ps, pd, rd);
    tx_wr = 0; pop = 0; push = 0; rx_rd = 0;
    check_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pndng"},    pndng,        32'h0);
    chk({tag, "_d_pop"},    D_pop,        32'h0);
    chk({tag, "_tx_full"},  tx_full,      32'h0);
    chk({tag, "_rx_valid"}, rx_valid,     32'h0);
    chk({tag, "_rx_data"},  rx_data,      32'h0);
    chk({tag, "_drop"},     drop_cnt,     32'h0);
    chk({tag, "_mis"},      misroute_cnt, 32'h0);
    chk({tag, "_und"},      err_underrun, 32'h0);
  endtask

  initial begin
    logic [15:0] rnd_pd;
    logic [7:0]  dsel;

    // Reset state
    #12;
    check_reset_outputs("rst");
    reset = 1'b0;
    model_clear();

    // TX flow
    cyc(1, 16'h0123, 0, 0, 16'h0, 0);
    chk("tx_flow_pndng", pndng, 32'h1);
    chk("tx_flow_head0", D_pop, 32'h0123);
    cyc(1, 16'h0456, 0, 0, 16'h0, 0);
    cyc(0, 16'h0, 1, 0, 16'h0, 0);
    chk("tx_flow_head1", D_pop, 32'h0456);
    cyc(0, 16'h0, 1, 0, 16'h0, 0);
    chk("tx_flow_empty", pndng, 32'h0);

    // RX filter
    cyc(0, 16'h0, 0, 1, 16'h02AA, 0);
    chk("rx_own_valid", rx_valid, 32'h1);
    chk("rx_own_data",  rx_data,  32'h02AA);
    cyc(0, 16'h0, 0, 1, 16'hFF55, 0);
    cyc(0, 16'h0, 0, 1, 16'h0311, 0);
    chk("rx_misroute", misroute_cnt, 32'h1);
    cyc(0, 16'h0, 0, 0, 16'h0, 1);
    chk("rx_bcast_data", rx_data, 32'hFF55);
    cyc(0, 16'h0, 0, 0, 16'h0, 1);

    // RX overflow
    for (int i = 0; i < 17; i++) cyc(0, 16'h0, 0, 1, 16'h0200 + 16'(i), 0);
    chk("rx_ovf_drop", drop_cnt, 32'h1);
    for (int i = 0; i < 16; i++) begin
      chk("rx_ovf_order", rx_data, 32'h0200 + 32'(i));
      cyc(0, 16'h0, 0, 0, 16'h0, 1);
    end
    chk("rx_ovf_drained", rx_valid, 32'h0);

    // TX full, ignored write, write+pop while full
    for (int i = 0; i < 16; i++) cyc(1, 16'h1000 + 16'(i), 0, 0, 16'h0, 0);
    chk("tx_full_set", tx_full, 32'h1);
    cyc(1, 16'hDEAD, 0, 0, 16'h0, 0);
    chk("tx_full_ignored_head", D_pop, 32'h1000);
    cyc(1, 16'hBEEF, 1, 0, 16'h0, 0);
    chk("tx_full_wrpop_full", tx_full, 32'h1);
    chk("tx_full_wrpop_head", D_pop, 32'h1001);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("tx_full_last_beef", D_pop, 32'hBEEF);
      cyc(0, 16'h0, 1, 0, 16'h0, 0);
    end

    // Underrun is sticky
    cyc(0, 16'h0, 1, 0, 16'h0, 0);
    chk("underrun_set", err_underrun, 32'h1);
    cyc(1, 16'h0777, 0, 1, 16'h0201, 0);
    cyc(0, 16'h0, 1, 0, 16'h0, 1);
    chk("underrun_held", err_underrun, 32'h1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      dsel = 8'($urandom_range(0, 3));
      rnd_pd = 16'($urandom);
      if (dsel == 0) rnd_pd[15:8] = MY_ID;
      else if (dsel == 1) rnd_pd[15:8] = 8'hFF;
      cyc(bit'($urandom_range(0, 1)), 16'($urandom), bit'($urandom_range(0, 2) == 0),
          bit'($urandom_range(0, 1)), rnd_pd, bit'($urandom_range(0, 2) == 0));
    end

    // Reset mid-operation with both FIFOs partly full
    while (tx_m.size() > 0 || rx_m.size() > 0) cyc(0, 16'h0, tx_m.size() > 0, 0, 16'h0, rx_m.size() > 0);
    for (int i = 0; i < 8; i++) cyc(1, 16'h3000 + 16'(i), 0, 1, 16'h0240 + 16'(i), 0);
    chk("mid_tx_half", pndng, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_clear();
    #2;
    reset = 1'b0;
    cyc(1, 16'h0123, 0, 0, 16'h0, 0);
    chk("post_rst_pndng", pndng, 32'h1);
    chk("post_rst_head",  D_pop, 32'h0123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
